// File: rtl/oversample_bit_timer.sv
// Bit-timing engine: counts oversample ticks per bit and emits mid-bit sample,
// end-of-bit and end-of-frame strobes for the serial shift logic.
module oversample_bit_timer #(
    parameter int OSF        = 8,
    parameter int NBITS      = 10,
    parameter int SAMPLE_POS = OSF / 2
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       EN,
    input  logic                       Start,
    input  logic                       Abort,
    input  logic                       Continuous,
    output logic                       Busy,
    output logic                       Sample,
    output logic                       BitEnd,
    output logic [$clog2(NBITS+1)-1:0] BitIdx,
    output logic                       FrameDone
);
    localparam int TW = $clog2(OSF) + 1;
    localparam int BW = $clog2(NBITS + 1);

    localparam logic [TW-1:0] T_LAST = TW'(OSF - 1);
    localparam logic [TW-1:0] T_SAMP = TW'(SAMPLE_POS - 1);
    localparam logic [BW-1:0] B_LAST = BW'(NBITS - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t          r_state;
    logic [TW-1:0]   r_tcnt;
    logic [BW-1:0]   r_bit_idx;
    logic            w_tick;
    logic            w_bit_end;
    logic            w_frame_done;

    // A counted tick; Abort masks every strobe in its own cycle.
    assign w_tick       = (r_state == RUN) & EN & ~Abort;
    assign w_bit_end    = w_tick & (r_tcnt == T_LAST);
    assign w_frame_done = w_bit_end & (r_bit_idx == B_LAST);

    assign Busy      = (r_state == RUN);
    assign Sample    = w_tick & (r_tcnt == T_SAMP);
    assign BitEnd    = w_bit_end;
    assign FrameDone = w_frame_done;
    assign BitIdx    = r_bit_idx;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_tcnt    <= '0;
            r_bit_idx <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Start && !Abort) begin
                        r_state   <= RUN;
                        r_tcnt    <= '0;
                        r_bit_idx <= '0;
                    end
                end
                RUN: begin
                    if (Abort) begin
                        r_state   <= IDLE;
                        r_tcnt    <= '0;
                        r_bit_idx <= '0;
                    end else if (w_frame_done) begin
                        r_tcnt    <= '0;
                        r_bit_idx <= '0;
                        if (!Continuous)
                            r_state <= IDLE;
                    end else if (w_bit_end) begin
                        r_tcnt    <= '0;
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end else if (EN) begin
                        r_tcnt    <= r_tcnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_tcnt    <= '0;
                    r_bit_idx <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_oversample_bit_timer.sv
// Bench: three parameterisations share stimulus; a frame-tick model checks every
// cycle, and directed scenarios pin strobe cycles with literal expectations.
module tb_oversample_bit_timer;
    logic Clk = 1'b0;
    logic Reset, EN, Start, Abort, Continuous;
    logic [2:0] busy, samp, be, fd;
    logic [3:0] idx0;
    logic [1:0] idx1;
    logic [0:0] idx2;

    always #5 Clk = ~Clk;

    oversample_bit_timer u0 (
        .Clk(Clk), .Reset(Reset), .EN(EN), .Start(Start), .Abort(Abort),
        .Continuous(Continuous), .Busy(busy[0]), .Sample(samp[0]), .BitEnd(be[0]),
        .BitIdx(idx0), .FrameDone(fd[0]));
    oversample_bit_timer #(.OSF(4), .NBITS(2), .SAMPLE_POS(2)) u1 (
        .Clk(Clk), .Reset(Reset), .EN(EN), .Start(Start), .Abort(Abort),
        .Continuous(Continuous), .Busy(busy[1]), .Sample(samp[1]), .BitEnd(be[1]),
        .BitIdx(idx1), .FrameDone(fd[1]));
    oversample_bit_timer #(.OSF(2), .NBITS(1), .SAMPLE_POS(2)) u2 (
        .Clk(Clk), .Reset(Reset), .EN(EN), .Start(Start), .Abort(Abort),
        .Continuous(Continuous), .Busy(busy[2]), .Sample(samp[2]), .BitEnd(be[2]),
        .BitIdx(idx2), .FrameDone(fd[2]));

    int osf[3] = '{8, 4, 2};
    int nb[3]  = '{10, 2, 1};
    int sp[3]  = '{4, 2, 2};

    // Model state: busy flag and number of ticks counted so far in the frame.
    int mb[3] = '{0, 0, 0};
    int mn[3] = '{0, 0, 0};

    int ecnt = 0, base = 0, total = 0, bad = 0;
    bit chk = 0;
    int q_s_cyc[$], q_s_idx[$], q_be[$], q_fd[$], p_samp[$], p_fd[$];
    int busy_fall, pn, fd2cnt;

    always @(posedge Clk) ecnt <= ecnt + 1;

    function automatic int cyc();
        return ecnt - base + 1;
    endfunction

    always @(negedge Clk) begin : cmp
        logic   eb, es, ebe, efd;
        integer ei, ai;
        int     pos;
        for (int i = 0; i < 3; i++) begin
            eb  = (mb[i] != 0);
            ei  = mn[i] / osf[i];
            pos = mn[i] % osf[i];
            es  = eb && EN && !Abort && (pos == sp[i] - 1);
            ebe = eb && EN && !Abort && (pos == osf[i] - 1);
            efd = ebe && (ei == nb[i] - 1);
            ai  = (i == 0) ? integer'(idx0) : (i == 1) ? integer'(idx1) : integer'(idx2);
            if (chk) begin
                total++;
                if ({busy[i], samp[i], be[i], fd[i]} !== {eb, es, ebe, efd} || ai !== ei) begin
                    bad++;
                    $display("FAIL model u%0d cyc=%0d got busy/samp/be/fd=%b idx=%0d want %b idx=%0d",
                             i, cyc(), {busy[i], samp[i], be[i], fd[i]}, ai,
                             {eb, es, ebe, efd}, ei);
                end
            end
            if (i == 0) begin
                if (samp[0] === 1'b1) begin q_s_cyc.push_back(cyc()); q_s_idx.push_back(int'(idx0)); end
                if (be[0] === 1'b1) q_be.push_back(cyc());
                if (fd[0] === 1'b1) q_fd.push_back(cyc());
                if (chk && busy_fall == 0 && busy[0] === 1'b0 && cyc() > 1) busy_fall = cyc();
            end else if (i == 1) begin
                if (eb && EN && !Abort) pn++;
                if (samp[1] === 1'b1) p_samp.push_back(pn);
                if (fd[1] === 1'b1) p_fd.push_back(pn);
            end else begin
                if (fd[2] === 1'b1) fd2cnt++;
            end
            // advance the model by one clock edge
            if (Reset) begin
                mb[i] = 0; mn[i] = 0;
            end else if (mb[i] == 0) begin
                if (Start && !Abort) begin mb[i] = 1; mn[i] = 0; end
            end else if (Abort) begin
                mb[i] = 0; mn[i] = 0;
            end else if (EN) begin
                mn[i]++;
                if (mn[i] == osf[i] * nb[i]) begin
                    mn[i] = 0;
                    mb[i] = Continuous ? 1 : 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk); #1;
    endtask

    task automatic run_to(input int c);
        while (cyc() < c) tick();
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        Reset = 1; Start = 0; Abort = 0; Continuous = 0; EN = 0;
        tick();
        chk = 1;
        tick();
        Reset = 0;
    endtask

    task automatic start_frame();
        Start = 1;
        tick();
        base = ecnt;
        Start = 0;
        q_s_cyc.delete(); q_s_idx.delete(); q_be.delete(); q_fd.delete();
        p_samp.delete(); p_fd.delete();
        busy_fall = 0; pn = 0; fd2cnt = 0;
    endtask

    task automatic check_default_frame(input string tag);
        chk_int({tag, "_samp_count"}, q_s_cyc.size(), 10);
        for (int k = 0; k < 10 && k < q_s_cyc.size(); k++) begin
            chk_int({tag, "_samp_cyc"}, q_s_cyc[k], 4 + 8 * k);
            chk_int({tag, "_samp_idx"}, q_s_idx[k], k);
        end
        chk_int({tag, "_be_count"}, q_be.size(), 10);
        for (int k = 0; k < 10 && k < q_be.size(); k++)
            chk_int({tag, "_be_cyc"}, q_be[k], 8 * k + 8);
        chk_int({tag, "_fd_count"}, q_fd.size(), 1);
        if (q_fd.size() > 0) chk_int({tag, "_fd_cyc"}, q_fd[0], 80);
        chk_int({tag, "_busy_fall"}, busy_fall, 81);
    endtask

    initial begin
        // defaults, EN held high
        do_reset();
        chk_int("reset_busy", int'(busy), 0);
        chk_int("reset_idx", int'(idx0), 0);
        EN = 1;
        start_frame();
        chk_int("start_latency_busy", int'(busy), 7);
        run_to(90);
        check_default_frame("dflt");
        chk_int("osf2_fd_count", fd2cnt, 1);

        // continuous across frames, then drop Continuous
        do_reset();
        EN = 1; Continuous = 1;
        start_frame();
        run_to(250);
        Continuous = 0;
        run_to(330);
        chk_int("cont_fd_count", q_fd.size(), 4);
        for (int k = 0; k < 4 && k < q_fd.size(); k++)
            chk_int("cont_fd_cyc", q_fd[k], 80 * (k + 1));
        chk_int("cont_busy_fall", busy_fall, 321);
        if (q_s_cyc.size() > 10) begin
            chk_int("cont_wrap_samp_cyc", q_s_cyc[10], 84);
            chk_int("cont_wrap_samp_idx", q_s_idx[10], 0);
        end else chk_int("cont_samp_count", q_s_cyc.size(), 40);
        chk_int("osf2_cont_fd_count", fd2cnt, 125);

        // ignored Start mid-frame, then Abort on a BitEnd cycle
        do_reset();
        EN = 1;
        start_frame();
        run_to(20);
        Start = 1;
        tick();
        Start = 0;
        run_to(40);
        Abort = 1;
        tick();
        Abort = 0;
        chk_int("abort_busy41", int'(busy[0]), 0);
        chk_int("abort_idx41", int'(idx0), 0);
        run_to(60);
        chk_int("abort_be_count", q_be.size(), 4);
        if (q_be.size() > 0) chk_int("abort_last_be", q_be[q_be.size() - 1], 32);
        chk_int("abort_fd_count", q_fd.size(), 0);
        chk_int("abort_samp_count", q_s_cyc.size(), 5);

        // reset mid-frame, then a fresh frame reproduces the default timing
        do_reset();
        EN = 1;
        start_frame();
        run_to(30);
        Reset = 1;
        tick();
        Reset = 0;
        chk_int("rst_outputs31", int'({busy, samp, be, fd}), 0);
        chk_int("rst_idx31", int'(idx0), 0);
        chk_int("rst_fd_count", q_fd.size(), 0);
        start_frame();
        run_to(90);
        check_default_frame("rerun");

        // sparse EN: 1-in-3 pulse train
        do_reset();
        start_frame();
        while (cyc() < 40) begin
            EN = (cyc() % 3 == 0);
            tick();
        end
        EN = 0;
        chk_int("sparse_samp_count", p_samp.size(), 2);
        if (p_samp.size() == 2) begin
            chk_int("sparse_samp_pulse0", p_samp[0], 2);
            chk_int("sparse_samp_pulse1", p_samp[1], 6);
        end
        chk_int("sparse_fd_count", p_fd.size(), 1);
        if (p_fd.size() > 0) chk_int("sparse_fd_pulse", p_fd[0], 8);
        chk_int("sparse_busy_end", int'(busy[1]), 0);

        // Start and Abort together while idle
        do_reset();
        EN = 1; Start = 1; Abort = 1;
        tick();
        Start = 0; Abort = 0;
        chk_int("start_abort_busy", int'(busy), 0);
        tick();
        chk_int("start_abort_busy2", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/oversample_bit_timer.md
# oversample_bit_timer

Parametrised bit-timing engine for the oversampled serial path. It counts oversample ticks (EN) within each bit period. It emits a mid-bit sample strobe and an end-of-bit strobe, tracks the bit index within a frame, and flags frame completion. Frames are single-shot or back-to-back, and can be aborted. It sits between the oversample tick generator and the receive/transmit shift logic, and provides the bit-period timing for the whole serial path.

## Interface
- OSF, 8, oversample ticks per bit; legal range 2..256
- NBITS, 10, bits per frame including start and stop; legal range 1..64
- SAMPLE_POS, OSF/2, tick within the bit (1..OSF) on which Sample fires
- Clk  in  1  clock; all logic on the rising edge
- Reset  in  1  reset: synchronous, active-high
- EN  in  1  oversample tick qualifier, one-cycle pulses or held high
- Start  in  1  begin a frame; honoured only when idle
- Abort  in  1  terminate the current frame immediately
- Continuous  in  1  at the end of a frame, start the next frame without idling
- Busy  out  1  frame in progress (registered)
- Sample  out  1  mid-bit strobe (combinational, one cycle)
- BitEnd  out  1  end-of-bit strobe (combinational, one cycle)
- BitIdx  out  $clog2(NBITS+1)  index of the current bit, 0..NBITS-1 (registered)
- FrameDone  out  1  last bit of the frame has ended (combinational, one cycle)

## Operation
- Internal state:
  - Busy register, with states IDLE (Busy=0) and RUN (Busy=1)
  - tick counter TCnt, width $clog2(OSF)+1, range 0..OSF-1
  - BitIdx register
- IDLE -> RUN when Start=1 and Abort=0. On that edge TCnt:=0 and BitIdx:=0. EN in the Start cycle is not counted.
- In RUN, each cycle with EN=1:
  - TCnt increments.
  - When TCnt==OSF-1, TCnt wraps to 0 and the bit ends.
  - In cycles with EN=0, the state holds.
- Sample = Busy & EN & ~Abort & (TCnt==SAMPLE_POS-1).
- BitEnd = Busy & EN & ~Abort & (TCnt==OSF-1).
- FrameDone = BitEnd & (BitIdx==NBITS-1).
- On BitEnd with BitIdx<NBITS-1: BitIdx increments.
- On FrameDone:
  - BitIdx:=0 and TCnt:=0.
  - If Continuous=1 in that cycle, the block stays in RUN; otherwise RUN -> IDLE.
- Start while in RUN is ignored and has no effect on the counters.
- Abort in RUN:
  - next state is IDLE, with TCnt:=0 and BitIdx:=0
  - all strobes are suppressed in the Abort cycle, including a coincident BitEnd or FrameDone
- Abort in IDLE has no effect. Abort and Start together in IDLE: the block stays IDLE.
- Priority: Reset > Abort > FrameDone/Continuous > BitEnd > EN count > Start.
- When SAMPLE_POS==OSF, Sample and BitEnd assert in the same cycle, and BitIdx still shows the bit being sampled.
- When OSF==2 and EN is held high, a strobe can occur on every cycle. No idle cycle is required between bits or between continuous frames.

## Timing
- Reset values: Busy=0, BitIdx=0, TCnt=0. Sample, BitEnd and FrameDone are therefore 0.
- Reset asserted mid-frame returns the block to IDLE on the next edge with no FrameDone. Reset has no other effect.
- Strobes are Mealy outputs. They are valid in the same cycle as the qualifying EN, with BitIdx giving the bit they belong to. BitIdx updates on the following edge.
- Start latency: Busy is high on the cycle after Start. The first counted EN can occur in that cycle.
- With EN held high, and Start sampled on edge 0:
  - Sample for bit k falls in cycle k*OSF+SAMPLE_POS.
  - BitEnd for bit k falls in cycle (k+1)*OSF.
  - FrameDone falls in cycle NBITS*OSF.
  - Busy drops at edge NBITS*OSF+1 (non-continuous).
- With sparse EN, all positions count EN pulses, not clocks.
- In continuous mode the next frame's first tick can be counted in the cycle right after FrameDone.

## Test plan
- Defaults, EN=1 constantly, pulse Start at cycle 0:
  - Sample at cycles 4, 12, …, 76 with BitIdx 0..9
  - BitEnd at cycles 8, 16, …, 80
  - FrameDone only at cycle 80
  - Busy low from cycle 81
- EN as a 1-in-3 pulse train, OSF=4, NBITS=2, SAMPLE_POS=2:
  - Sample on the 2nd and 6th counted EN pulses
  - FrameDone on the 8th counted EN pulse
  - strobes never assert in cycles with EN=0
- Continuous=1 across 3 frames: BitIdx wraps 9->0 with no gap cycle, and FrameDone pulses at cycles 80, 160 and 240. Then drop Continuous: Busy falls after the 4th FrameDone.
- Abort in cycle 40 (coincident with a BitEnd): no BitEnd or FrameDone in that cycle, Busy=0 at cycle 41, BitIdx=0. A Start issued during the frame before the abort was ignored.
- Reset at cycle 30 mid-frame: all outputs 0 at cycle 31. A fresh Start then reproduces the timing of the first scenario exactly.
- Corner parameters:
  - OSF=2, SAMPLE_POS=2, NBITS=1: Sample, BitEnd and FrameDone coincide every 2nd EN.
  - Start and Abort together in IDLE: Busy stays 0.
